cmd_bus_arbiter: RTL and testbench
==================================

Name: cmd_bus_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 4-bit address/data command bus (valid/ack handshake) between N_REQ requesters, e.g. the UART command decoder and the button/switch front-end.
- Sits between the requesters and the bus slaves (channel processor and peers).
- Issues one transaction at a time and enforces the slave handshake timing.
- Routes the slave's read-back nibble to the issuing requester.
- Times out transactions that are never acknowledged.

Parameters:
N_REQ, 2, number of requesters (2..4).
TIMEOUT, 15, maximum cycles in WAIT before abort (1..2^TO_W-1).
TO_W, 4, timeout counter width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  N_REQ  per-requester request; held high until that requester's req_done
req_address  in  4*N_REQ  request address, requester i at bits [4i+3:4i]
req_data  in  4*N_REQ  request data, same packing
req_done  out  N_REQ  one-cycle completion pulse to the granted requester
req_timeout  out  1  status, valid with req_done: 1=aborted on timeout, 0=acknowledged
resp_data  out  4  read-back nibble, valid with req_done when resp_valid=1
resp_valid  out  1  1 if the slave returned data for this transaction
grant  out  N_REQ  one-hot owner of the current transaction, 0 when idle
bus_address  out  4  to slaves
bus_data  out  4  to slaves
bus_valid  out  1  to slaves
bus_ack  in  1  slave acknowledge, one-cycle pulse
bus_rdata  in  4  slave read-back data
bus_rdata_valid  in  1  slave read-back qualifier, coincident with bus_ack

Behaviour:
- All outputs are registered. Reset (asynchronous, any state) forces state=IDLE, all outputs to 0, round-robin pointer to 0 and the timeout counter to 0. bus_valid drops immediately on reset assertion.
- FSM states: IDLE, WAIT, GAP.
- IDLE:
  - If any req_valid bit is high, select the first set bit at or after index ptr, searching upward and wrapping.
  - At that edge: latch that requester's address and data onto bus_address/bus_data, set bus_valid=1, set grant to that one-hot, clear the counter, set ptr=(winner+1) mod N_REQ, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - bus_address, bus_data and grant are held stable.
  - bus_ack=1: set bus_valid=0, pulse req_done[winner], req_timeout=0, resp_valid=bus_rdata_valid, resp_data=bus_rdata (0 if not valid), go to GAP.
  - Else if counter==TIMEOUT-1: set bus_valid=0, pulse req_done[winner], req_timeout=1, resp_valid=0, resp_data=0, go to GAP.
  - Else: counter+1.
  - Ack wins over timeout in the same cycle.
- GAP:
  - Exactly one cycle. grant=0, bus_address/bus_data cleared to 0, req_done/resp_* cleared. Go to IDLE.
  - Guarantees bus_valid is low for at least two cycles between transactions, so the slave's ack-recovery cycle is never overlapped.
  - Gives a registered requester time to drop req_valid after req_done.
- Latency: request seen at edge k → bus_valid high after k. Slave acks after k+1 → req_done high after k+2. Next grant is possible at edge k+4 at the earliest.
- Slaves silently ignore some addresses (e.g. address 0 writes take effect without an ack), so these complete by timeout with req_timeout=1. This is legal; requesters treat it as write-done-unconfirmed.
- Requester drops req_valid mid-WAIT: the transaction runs to completion and req_done still pulses. Latched address/data are unaffected.
- Requester asserts req_valid while another is granted: that requester waits; there is no queue beyond req_valid itself.
- Stray bus_ack in IDLE or GAP: ignored, no output change.
- Round-robin fairness: with all requesters continuously requesting, grants rotate 0,1,...,N_REQ-1,0.

Test Plan:
- Single read: req0 addr=0010 data=1111; slave acks with rdata=0011 one cycle after bus_valid → bus_valid high 2 cycles, req_done=01 pulse, resp_valid=1, resp_data=0011, req_timeout=0.
- Write with no ack: req1 addr=0000 data=0000; slave silent → bus_valid high exactly 15 cycles, then req_done=10, req_timeout=1, resp_valid=0, grant=00 in GAP.
- Contention: req0 and req1 both held high with addr=0010 data=0001/0010 → grants 01,10,01,10; each grant is separated by bus_valid low for at least 2 cycles; bus_data matches the owner.
- Ack on last timeout cycle: ack arrives when counter==14 → req_timeout=0, resp captured normally.
- Reset mid-WAIT: assert rst while bus_valid=1 → bus_valid, grant and req_done go to 0 immediately; after release, req1 pending is granted first because ptr=0 and req0 is idle.
- Early drop: req0 deasserts req_valid one cycle into WAIT; slave acks → req_done[0] still pulses, and no new grant is issued until req_valid rises again.

Source files
------------

// File: rtl/cmd_bus_arbiter.sv
// rtl/cmd_bus_arbiter.sv - round-robin arbiter/sequencer for the shared 4-bit command bus
// Grants one requester at a time, tracks the slave ack with a timeout, returns read-back data.
module cmd_bus_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [4*N_REQ-1:0] req_address,
  input  logic [4*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_done,
  output logic               req_timeout,
  output logic [3:0]         resp_data,
  output logic               resp_valid,
  output logic [N_REQ-1:0]   grant,
  output logic [3:0]         bus_address,
  output logic [3:0]         bus_data,
  output logic               bus_valid,
  input  logic               bus_ack,
  input  logic [3:0]         bus_rdata,
  input  logic               bus_rdata_valid
);

  localparam int PW = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_q;
  logic [TO_W-1:0] cnt_q;

  logic            found_d;
  logic [PW-1:0]   win_d;
  logic [PW-1:0]   ptr_d;
  int              idx;

  // Search upward from the round-robin pointer, wrapping, for the first pending request.
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found_d && req_valid[idx]) begin
        found_d = 1'b1;
        win_d   = PW'(idx);
      end
    end
    ptr_d = PW'((int'(win_d) + 1) % N_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      req_done    <= '0;
      req_timeout <= 1'b0;
      resp_data   <= 4'h0;
      resp_valid  <= 1'b0;
      grant       <= '0;
      bus_address <= 4'h0;
      bus_data    <= 4'h0;
      bus_valid   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            bus_address <= req_address[4*int'(win_d) +: 4];
            bus_data    <= req_data[4*int'(win_d) +: 4];
            bus_valid   <= 1'b1;
            grant       <= {{(N_REQ-1){1'b0}}, 1'b1} << win_d;
            win_q       <= win_d;
            ptr_q       <= ptr_d;
            cnt_q       <= '0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // An ack in the final timeout cycle still counts as an acknowledge.
          if (bus_ack) begin
            bus_valid       <= 1'b0;
            req_done[win_q] <= 1'b1;
            req_timeout     <= 1'b0;
            resp_valid      <= bus_rdata_valid;
            resp_data       <= bus_rdata_valid ? bus_rdata : 4'h0;
            state_q         <= GAP;
          end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
            bus_valid       <= 1'b0;
            req_done[win_q] <= 1'b1;
            req_timeout     <= 1'b1;
            resp_valid      <= 1'b0;
            resp_data       <= 4'h0;
            state_q         <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          grant       <= '0;
          bus_address <= 4'h0;
          bus_data    <= 4'h0;
          req_done    <= '0;
          req_timeout <= 1'b0;
          resp_valid  <= 1'b0;
          resp_data   <= 4'h0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// tb/tb_cmd_bus_arbiter.sv - self-checking bench for cmd_bus_arbiter
// Transaction-level reference: round-robin pick, ack-delay vs timeout arithmetic.
module tb_cmd_bus_arbiter;
  localparam int N  = 2;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_address, req_data;
  logic [N-1:0]   req_done, grant;
  logic           req_timeout, resp_valid, bus_valid;
  logic [3:0]     resp_data, bus_address, bus_data;
  logic           bus_ack, bus_rdata_valid;
  logic [3:0]     bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  always #5 clk = ~clk;

  cmd_bus_arbiter #(.N_REQ(N), .TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_address(req_address), .req_data(req_data),
    .req_done(req_done), .req_timeout(req_timeout),
    .resp_data(resp_data), .resp_valid(resp_valid), .grant(grant),
    .bus_address(bus_address), .bus_data(bus_data), .bus_valid(bus_valid),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_rdata_valid(bus_rdata_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One full transaction: grant, d-cycle ack delay (d > TO means never), GAP.
  task automatic do_txn(input int d, input logic [3:0] rd, input logic rdv,
                        input logic keep, input logic drop_early);
    int w, fin, budget;
    logic [N-1:0] eg;
    logic [3:0] ea, ed;
    w = pick(req_valid, m_ptr);
    if (w < 0) begin
      n_checks++; n_fail++;
      $display("FAIL txn_setup: no pending request");
      return;
    end
    eg = '0; eg[w] = 1'b1;
    ea = req_address[4*w +: 4];
    ed = req_data[4*w +: 4];
    fin = (d <= TO) ? d : TO;
    budget = 0;
    do begin tick(); budget++; end while (!bus_valid && budget < 8);
    n_checks++;
    if ({bus_valid, grant, bus_address, bus_data, req_done} !== {1'b1, eg, ea, ed, {N{1'b0}}}) begin
      n_fail++;
      $display("FAIL grant: got v=%b g=%b a=%h d=%h done=%b want v=1 g=%b a=%h d=%h done=0",
               bus_valid, grant, bus_address, bus_data, req_done, eg, ea, ed);
      return;
    end
    m_ptr = (w + 1) % N;
    for (int j = 1; j <= fin; j++) begin
      bus_ack = (j == d);
      bus_rdata = rd;
      bus_rdata_valid = rdv && (j == d);
      if (j == 1 && drop_early) req_valid[w] = 1'b0;
      tick();
      if (j < fin) begin
        n_checks++;
        if ({bus_valid, grant, bus_address, bus_data, req_done} !== {1'b1, eg, ea, ed, {N{1'b0}}}) begin
          n_fail++;
          $display("FAIL wait_hold c%0d: got v=%b g=%b a=%h d=%h done=%b want v=1 g=%b a=%h d=%h done=0",
                   j, bus_valid, grant, bus_address, bus_data, req_done, eg, ea, ed);
        end
      end else begin
        n_checks++;
        if ({bus_valid, req_done, req_timeout, resp_valid, resp_data} !==
            {1'b0, eg, (d > TO), (d <= TO) && rdv, ((d <= TO) && rdv) ? rd : 4'h0}) begin
          n_fail++;
          $display("FAIL done c%0d: got v=%b done=%b to=%b rv=%b rd=%h want v=0 done=%b to=%b rv=%b rd=%h",
                   j, bus_valid, req_done, req_timeout, resp_valid, resp_data, eg,
                   (d > TO), (d <= TO) && rdv, ((d <= TO) && rdv) ? rd : 4'h0);
        end
      end
    end
    bus_ack = 1'b0;
    bus_rdata_valid = 1'b0;
    if (!keep) req_valid[w] = 1'b0;
    tick();
    n_checks++;
    if ({bus_valid, grant, bus_address, bus_data, req_done, resp_valid, resp_data} !== '0) begin
      n_fail++;
      $display("FAIL gap: got v=%b g=%b a=%h d=%h done=%b rv=%b rd=%h want all 0",
               bus_valid, grant, bus_address, bus_data, req_done, resp_valid, resp_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_address = '0; req_data = '0;
    bus_ack = 1'b0; bus_rdata = 4'h0; bus_rdata_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if ({req_done, req_timeout, resp_data, resp_valid, grant, bus_address, bus_data, bus_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset: got done=%b g=%b v=%b a=%h d=%h want all 0", req_done, grant, bus_valid, bus_address, bus_data);
    end
    rst = 1'b0; m_ptr = 0;
    tick();
  endtask

  task automatic test_single_read();
    req_address[3:0] = 4'b0010; req_data[3:0] = 4'b1111; req_valid = 2'b01;
    do_txn(2, 4'b0011, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_write_timeout();
    req_address[7:4] = 4'b0000; req_data[7:4] = 4'b0000; req_valid = 2'b10;
    do_txn(99, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_contention();
    req_address = {4'b0010, 4'b0010}; req_data = {4'b0010, 4'b0001}; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) do_txn(2, 4'h5, 1'b0, 1'b1, 1'b0);
    req_valid = '0;
    tick();
  endtask

  task automatic test_ack_last_cycle();
    req_address[3:0] = 4'h7; req_data[3:0] = 4'h9; req_valid = 2'b01;
    do_txn(TO, 4'hA, 1'b1, 1'b0, 1'b0);
    req_address[7:4] = 4'h3; req_data[7:4] = 4'hC; req_valid = 2'b10;
    do_txn(TO - 1, 4'h6, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stray_ack();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      bus_ack = 1'b1; bus_rdata_valid = 1'b1; bus_rdata = 4'hF;
      tick();
      n_checks++;
      if ({bus_valid, grant, req_done, resp_valid, resp_data, req_timeout} !== '0) begin
        n_fail++;
        $display("FAIL stray_ack: got v=%b g=%b done=%b rv=%b rd=%h want all 0",
                 bus_valid, grant, req_done, resp_valid, resp_data);
      end
    end
    bus_ack = 1'b0; bus_rdata_valid = 1'b0;
  endtask

  task automatic test_early_drop();
    req_address[3:0] = 4'h4; req_data[3:0] = 4'hB; req_valid = 2'b01;
    do_txn(3, 4'h2, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({bus_valid, grant} !== '0) begin
        n_fail++;
        $display("FAIL early_drop_idle: got v=%b g=%b want v=0 g=0", bus_valid, grant);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    req_address[3:0] = 4'h1; req_data[3:0] = 4'h8; req_valid = 2'b01;
    tick(); tick();
    n_checks++;
    if (bus_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_grant: got v=%b want 1", bus_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_valid, grant, req_done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b g=%b done=%b want all 0", bus_valid, grant, req_done);
    end
    req_valid = '0;
    m_ptr = 0;
    tick();
    rst = 1'b0;
    req_address[7:4] = 4'hD; req_data[7:4] = 4'hE; req_valid = 2'b10;
    do_txn(2, 4'h1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] nb;
    for (int t = 0; t < 30; t++) begin
      nb = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (nb[i] && !req_valid[i]) begin
          req_address[4*i +: 4] = 4'($urandom);
          req_data[4*i +: 4]    = 4'($urandom);
          req_valid[i]          = 1'b1;
        end
      end
      do_txn($urandom_range(1, TO + 3), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_timeout();
    test_contention();
    test_ack_last_cycle();
    test_stray_ack();
    test_early_drop();
    test_reset_mid_wait();
    test_random();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
